// File: rtl/edsac_pkg.sv
// Shared encodings for the EDSAC-style core: FSM states, opcode letters, decoded ops.
package edsac_pkg;

    typedef enum logic [2:0] {HALTED, FETCH, DECODE, RWMEM, EXECUTE} state_t;

    // Opcode field holds the instruction letter minus '@'
    localparam logic [4:0] LET_A = 5'd1;
    localparam logic [4:0] LET_C = 5'd3;
    localparam logic [4:0] LET_E = 5'd5;
    localparam logic [4:0] LET_G = 5'd7;
    localparam logic [4:0] LET_I = 5'd9;
    localparam logic [4:0] LET_L = 5'd12;
    localparam logic [4:0] LET_O = 5'd15;
    localparam logic [4:0] LET_R = 5'd18;
    localparam logic [4:0] LET_S = 5'd19;
    localparam logic [4:0] LET_T = 5'd20;
    localparam logic [4:0] LET_U = 5'd21;
    localparam logic [4:0] LET_V = 5'd22;
    localparam logic [4:0] LET_Z = 5'd26;

    typedef enum logic [3:0] {
        OP_A, OP_C, OP_E, OP_G, OP_I, OP_L, OP_O,
        OP_R, OP_S, OP_T, OP_U, OP_V, OP_Z, OP_BAD
    } dop_t;

    typedef enum logic [1:0] {MS_SHL, MS_SHR, MS_MUL} ms_op_t;

    function automatic dop_t decode_op(input logic [4:0] code);
        case (code)
            LET_A:   return OP_A;
            LET_C:   return OP_C;
            LET_E:   return OP_E;
            LET_G:   return OP_G;
            LET_I:   return OP_I;
            LET_L:   return OP_L;
            LET_O:   return OP_O;
            LET_R:   return OP_R;
            LET_S:   return OP_S;
            LET_T:   return OP_T;
            LET_U:   return OP_U;
            LET_V:   return OP_V;
            LET_Z:   return OP_Z;
            default: return OP_BAD;
        endcase
    endfunction

endpackage

// File: rtl/edsac_mulshift.sv
// Iterative unit: one-bit-per-cycle shifts (max(count,1) cycles) and a
// 2W+1 cycle signed shift-add multiply of acc high half by mdata.
module edsac_mulshift
    import edsac_pkg::*;
#(
    parameter int WBITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               en,
    input  ms_op_t             op,
    input  logic [5:0]         count,
    input  logic [2*WBITS-1:0] acc,
    input  logic [WBITS-1:0]   mdata,
    output logic [2*WBITS-1:0] result,
    output logic               done
);
    localparam int AW = 2*WBITS;

    logic          active;
    logic          first;
    logic [7:0]    rem;
    logic [7:0]    total;
    logic [AW-1:0] mcand;
    logic [AW-1:0] mplier;
    logic [AW-1:0] prod;
    logic [AW-1:0] addend;

    always_comb begin
        first  = start && !active;
        if (op == MS_MUL)
            total = 8'(AW + 1);
        else if (count == 6'd0)
            total = 8'd1;
        else
            total = {2'b00, count};
        addend = mplier[0] ? mcand : '0;
        done   = start && (first ? (total == 8'd1) : (rem == 8'd1));
        result = acc;
        case (op)
            MS_SHL:  if (count != 6'd0) result = {acc[AW-2:0], 1'b0};
            MS_SHR:  if (count != 6'd0) result = {acc[AW-1], acc[AW-1:1]};
            default: if (done) result = prod + addend;
        endcase
    end

    // Operands are sign-extended to 2W so 2W unsigned shift-add steps yield the signed product
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            rem    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (start && en) begin
            active <= !done;
            if (first) begin
                rem    <= total - 8'd1;
                mcand  <= {{WBITS{acc[AW-1]}}, acc[AW-1:WBITS]};
                mplier <= {{WBITS{mdata[WBITS-1]}}, mdata};
                prod   <= '0;
            end else begin
                rem    <= rem - 8'd1;
                prod   <= prod + addend;
                mcand  <= {mcand[AW-2:0], 1'b0};
                mplier <= {1'b0, mplier[AW-1:1]};
            end
        end
    end

endmodule

// File: rtl/edsac_core.sv
// EDSAC-style accumulator machine: HALTED/FETCH/DECODE/RWMEM/EXECUTE sequencer.
// txwait or a pending receive freezes all architectural state.
module edsac_core
    import edsac_pkg::*;
#(
    parameter int ABITS      = 10,
    parameter int WBITS      = 16,
    parameter int RESET_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               memrd,
    output logic               memwr,
    input  logic               memwait,
    output logic [ABITS-1:0]   memaddr,
    input  logic [WBITS-1:0]   memrdata,
    output logic [WBITS-1:0]   memwdata,
    output logic [7:0]         txdata,
    output logic               txstart,
    input  logic               txwait,
    input  logic [7:0]         rxdata,
    output logic               rxstart,
    input  logic               rxwait,
    input  logic               run,
    output logic               halted,
    output logic               illegal,
    output logic [ABITS-1:0]   iaddrout,
    output logic [2*WBITS-1:0] accout
);
    localparam int AW = 2*WBITS;

    state_t           state;
    logic [ABITS-1:0] iaddr;
    logic [ABITS-1:0] iaddr_inc;
    logic [ABITS-1:0] addr;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    ms_result;
    logic [WBITS-1:0] ir;
    logic [WBITS-1:0] opdata;
    dop_t             dop;
    ms_op_t           ms_op;
    logic             stall;
    logic             is_write;
    logic             ms_start;
    logic             ms_done;
    logic             unused_ir_bits;

    always_comb begin
        dop       = decode_op(ir[WBITS-1 -: 5]);
        addr      = ir[ABITS-1:0];
        iaddr_inc = iaddr + ABITS'(1);
        is_write  = (dop == OP_T) || (dop == OP_U);
        stall     = txwait || (rxstart && rxwait);
        ms_start  = (state == EXECUTE) && (dop inside {OP_L, OP_R, OP_V});
        ms_op     = (dop == OP_V) ? MS_MUL : ((dop == OP_R) ? MS_SHR : MS_SHL);
    end

    assign unused_ir_bits = ^ir;
    assign memrd    = (state == FETCH) || ((state == RWMEM) && !is_write);
    assign memwr    = (state == RWMEM) && is_write;
    assign memaddr  = (state == FETCH) ? iaddr : addr;
    assign memwdata = acc[AW-1:WBITS];
    assign iaddrout = iaddr;
    assign accout   = acc;

    edsac_mulshift #(.WBITS(WBITS)) u_mulshift (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (ms_start),
        .en     (!stall),
        .op     (ms_op),
        .count  (ir[5:0]),
        .acc    (acc),
        .mdata  (opdata),
        .result (ms_result),
        .done   (ms_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            iaddr   <= ABITS'(RESET_ADDR);
            acc     <= '0;
            ir      <= '0;
            opdata  <= '0;
            txdata  <= '0;
            txstart <= 1'b0;
            rxstart <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            // txstart is a one-cycle pulse even if the transmitter then stalls us
            txstart <= 1'b0;
            if (!stall) begin
                case (state)
                    HALTED: if (run) begin
                        halted  <= 1'b0;
                        illegal <= 1'b0;
                        iaddr   <= iaddr_inc;
                        state   <= FETCH;
                    end
                    FETCH: if (!memwait) begin
                        ir    <= memrdata;
                        state <= DECODE;
                    end
                    DECODE: case (dop)
                        OP_A, OP_C, OP_S, OP_V, OP_O, OP_T, OP_U: state <= RWMEM;
                        OP_Z: begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end
                        OP_BAD: begin
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                            state   <= HALTED;
                        end
                        OP_I: begin
                            rxstart <= 1'b1;
                            state   <= EXECUTE;
                        end
                        default: state <= EXECUTE;
                    endcase
                    RWMEM: if (!memwait) begin
                        if (!is_write) opdata <= memrdata;
                        state <= EXECUTE;
                    end
                    EXECUTE: begin
                        case (dop)
                            OP_A: acc <= acc + {opdata, {WBITS{1'b0}}};
                            OP_S: acc <= acc - {opdata, {WBITS{1'b0}}};
                            OP_C: acc[AW-1:WBITS] <= acc[AW-1:WBITS] & opdata;
                            OP_T: acc <= '0;
                            OP_I: begin
                                acc     <= {{(WBITS-8){1'b0}}, rxdata, {WBITS{1'b0}}};
                                rxstart <= 1'b0;
                            end
                            OP_O: begin
                                txdata  <= opdata[7:0];
                                txstart <= 1'b1;
                            end
                            OP_L, OP_R, OP_V: acc <= ms_result;
                            default: ;
                        endcase
                        if (!ms_start || ms_done) begin
                            state <= FETCH;
                            if ((dop == OP_E && !acc[AW-1]) || (dop == OP_G && acc[AW-1]))
                                iaddr <= addr;
                            else
                                iaddr <= iaddr_inc;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_edsac_core.sv
// Directed and randomized program checks of edsac_core against an instruction-level model.
module tb_edsac_core;
    import edsac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memrd, memwr, memwait = 1'b0;
    logic [9:0]  memaddr;
    logic [15:0] memrdata, memwdata;
    logic [7:0]  txdata, rxdata = 8'h00;
    logic        txstart, txwait = 1'b0, rxstart, rxwait = 1'b0, run = 1'b0;
    logic        halted, illegal;
    logic [9:0]  iaddrout;
    logic [31:0] accout;

    logic [15:0] mem [0:1023];
    logic [15:0] mm  [0:1023];
    int          checks = 0;
    int          failures = 0;
    int          ex_cnt = 0;
    bit          rnd_wait = 1'b0;
    logic [7:0]  rxbyte;
    byte         ops [12];

    assign memrdata = mem[memaddr];

    always #5 clk = ~clk;

    edsac_core dut (
        .clk(clk), .rst_n(rst_n), .memrd(memrd), .memwr(memwr), .memwait(memwait),
        .memaddr(memaddr), .memrdata(memrdata), .memwdata(memwdata),
        .txdata(txdata), .txstart(txstart), .txwait(txwait),
        .rxdata(rxdata), .rxstart(rxstart), .rxwait(rxwait), .run(run),
        .halted(halted), .illegal(illegal), .iaddrout(iaddrout), .accout(accout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: memory write on the edge, then sample/drive 1 time unit later
    task automatic tick();
        logic wr;
        logic [9:0] wa;
        logic [15:0] wd;
        wr = memwr && !memwait;
        wa = memaddr;
        wd = memwdata;
        @(posedge clk);
        if (wr) mem[wa] = wd;
        #1;
        if (dut.state == EXECUTE) ex_cnt++;
        memwait = rnd_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
    endtask

    task automatic do_reset();
        rnd_wait = 1'b0;
        memwait = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ex_cnt = 0;
    endtask

    task automatic run_until_halt(input string tag);
        for (int k = 0; k < 4000 && halted !== 1'b1; k++) tick();
        chk({tag, "_halt_reached"}, halted, 1'b1);
    endtask

    function automatic logic [15:0] enc(input byte l, input int opnd);
        logic [7:0] c;
        logic [31:0] o;
        c = l - 8'h40;
        o = opnd;
        return {c[4:0], o[10:0]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 16'h0000;
            mm[i] = 16'h0000;
        end
    endtask

    task automatic put(input int a, input logic [15:0] v);
        mem[a] = v;
        mm[a] = v;
    endtask

    // Instruction-at-a-time interpreter; also totals the EXECUTE cycles each op costs
    task automatic model_run(output logic [31:0] macc, output int mpc, output int mex);
        logic [31:0] acc;
        logic [15:0] w, hi;
        logic [4:0]  code;
        logic signed [31:0] x, y;
        int pc, npc, n, a;
        acc = 0;
        pc = 0;
        mex = 0;
        for (int k = 0; k < 1000; k++) begin
            w = mm[pc];
            code = w[15:11];
            a = int'(w[9:0]);
            n = int'(w[5:0]);
            hi = mm[a];
            if (code == 5'd26) break;
            npc = (pc + 1) % 1024;
            mex += 1;
            case (code)
                5'd1:  acc = acc + {hi, 16'h0000};
                5'd19: acc = acc - {hi, 16'h0000};
                5'd3:  acc[31:16] = acc[31:16] & hi;
                5'd20: begin mm[a] = acc[31:16]; acc = 32'h0; end
                5'd21: mm[a] = acc[31:16];
                5'd9:  acc = {8'h00, rxbyte, 16'h0000};
                5'd5:  if (acc[31] == 1'b0) npc = a;
                5'd7:  if (acc[31] == 1'b1) npc = a;
                5'd12: begin acc = acc << n; if (n > 1) mex += n - 1; end
                5'd18: begin acc = $signed(acc) >>> n; if (n > 1) mex += n - 1; end
                5'd22: begin
                    x = $signed(acc[31:16]);
                    y = $signed(hi);
                    acc = x * y;
                    mex += 32;
                end
                default: ;
            endcase
            pc = npc;
        end
        macc = acc;
        mpc = pc;
    endtask

    initial begin
        logic [31:0] macc;
        int mpc, mex, nprog, opnd;
        byte l;
        ops = '{"A", "S", "C", "V", "T", "U", "L", "R", "E", "G", "O", "I"};

        // Reset state and A instruction
        clear_mem();
        put(0, enc("A", 30)); put(1, enc("A", 20)); put(2, enc("Z", 0));
        put(30, 16'h0003); put(20, 16'h0005);
        do_reset();
        chk("rst_memrd", memrd, 1'b1);
        chk("rst_memaddr", memaddr, 10'd0);
        chk("rst_acc", accout, 32'h0);
        chk("rst_iaddr", iaddrout, 10'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_txstart", txstart, 1'b0);
        chk("rst_rxstart", rxstart, 1'b0);
        chk("rst_memwr", memwr, 1'b0);
        rnd_wait = 1'b1;
        run_until_halt("add");
        chk("add_acc", accout, 32'h00080000);
        chk("add_iaddr", iaddrout, 10'd2);
        chk("add_exec_cycles", ex_cnt, 2);

        // Signed multiply
        clear_mem();
        put(0, enc("A", 31)); put(1, enc("V", 21)); put(2, enc("Z", 0));
        put(31, 16'hFFFD); put(21, 16'h0005);
        do_reset();
        run_until_halt("mul");
        chk("mul_acc", accout, 32'hFFFFFFF1);
        chk("mul_exec_cycles", ex_cnt, 34);

        // L 0 and R 3
        clear_mem();
        put(0, enc("A", 30)); put(1, enc("L", 0)); put(2, enc("Z", 0)); put(30, 16'h0003);
        do_reset();
        run_until_halt("l0");
        chk("l0_acc", accout, 32'h00030000);
        chk("l0_exec_cycles", ex_cnt, 2);
        clear_mem();
        put(0, enc("A", 32)); put(1, enc("R", 3)); put(2, enc("Z", 0)); put(32, 16'h8000);
        do_reset();
        run_until_halt("r3");
        chk("r3_acc", accout, 32'hF0000000);
        chk("r3_exec_cycles", ex_cnt, 4);

        // C, U, T, S and both branch polarities
        clear_mem();
        put(0, enc("A", 35)); put(1, enc("C", 34)); put(2, enc("U", 40)); put(3, enc("G", 9));
        put(4, enc("S", 30)); put(5, enc("T", 41)); put(6, enc("S", 30)); put(7, enc("G", 9));
        put(8, enc("Z", 0)); put(9, enc("E", 8)); put(10, enc("Z", 0));
        put(30, 16'h0003); put(34, 16'h00F5); put(35, 16'h0FFF);
        do_reset();
        rnd_wait = 1'b1;
        run_until_halt("misc");
        chk("misc_acc", accout, 32'hFFFD0000);
        chk("misc_iaddr", iaddrout, 10'd10);
        chk("misc_mem40", mem[40], 16'h00F5);
        chk("misc_mem41", mem[41], 16'h00F2);
        chk("misc_exec_cycles", ex_cnt, 9);

        // Undefined opcode, then resume with run
        clear_mem();
        put(0, enc("E", 7)); put(7, enc("B", 0)); put(8, enc("A", 30)); put(9, enc("Z", 0));
        put(30, 16'h0003);
        do_reset();
        run_until_halt("ill");
        chk("ill_illegal", illegal, 1'b1);
        chk("ill_iaddr", iaddrout, 10'd7);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("run_halted_clr", halted, 1'b0);
        chk("run_illegal_clr", illegal, 1'b0);
        chk("run_memrd", memrd, 1'b1);
        chk("run_memaddr", memaddr, 10'd8);
        run_until_halt("resume");
        chk("resume_acc", accout, 32'h00030000);
        chk("resume_iaddr", iaddrout, 10'd9);
        chk("resume_illegal", illegal, 1'b0);

        // Transmit with txwait stall
        clear_mem();
        put(0, enc("O", 33)); put(1, enc("A", 30)); put(2, enc("Z", 0));
        put(33, 16'h1241); put(30, 16'h0003);
        do_reset();
        for (int k = 0; k < 20 && txstart !== 1'b1; k++) tick();
        chk("tx_pulse_seen", txstart, 1'b1);
        chk("tx_data", txdata, 8'h41);
        chk("tx_fetch_addr", memaddr, 10'd1);
        txwait = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("tx_pulse_width", txstart, 1'b0);
        chk("tx_stall_iaddr", iaddrout, 10'd1);
        chk("tx_stall_acc", accout, 32'h0);
        chk("tx_stall_memrd", memrd, 1'b1);
        chk("tx_stall_memaddr", memaddr, 10'd1);
        txwait = 1'b0;
        run_until_halt("tx");
        chk("tx_final_acc", accout, 32'h00030000);
        chk("tx_final_iaddr", iaddrout, 10'd2);

        // Receive with rxwait stall
        clear_mem();
        put(0, enc("I", 0)); put(1, enc("Z", 0));
        rxwait = 1'b1;
        rxdata = 8'h3C;
        do_reset();
        for (int k = 0; k < 20 && rxstart !== 1'b1; k++) tick();
        chk("rx_start_seen", rxstart, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        chk("rx_wait_rxstart", rxstart, 1'b1);
        chk("rx_wait_acc", accout, 32'h0);
        chk("rx_wait_iaddr", iaddrout, 10'd0);
        rxdata = 8'hA5;
        rxwait = 1'b0;
        tick();
        chk("rx_acc", accout, 32'h00A50000);
        chk("rx_done_rxstart", rxstart, 1'b0);
        run_until_halt("rx");
        chk("rx_iaddr", iaddrout, 10'd1);

        // Reset in the middle of a multiply
        clear_mem();
        put(0, enc("A", 31)); put(1, enc("V", 21)); put(2, enc("Z", 0));
        put(31, 16'hFFFD); put(21, 16'h0005);
        do_reset();
        for (int k = 0; k < 15; k++) tick();
        rst_n = 1'b0;
        tick();
        chk("midv_rst_acc", accout, 32'h0);
        chk("midv_rst_iaddr", iaddrout, 10'd0);
        chk("midv_rst_memrd", memrd, 1'b1);
        chk("midv_rst_memaddr", memaddr, 10'd0);
        rst_n = 1'b1;
        ex_cnt = 0;
        run_until_halt("midv");
        chk("midv_acc", accout, 32'hFFFFFFF1);
        chk("midv_exec_cycles", ex_cnt, 34);

        // Random straight-line programs with forward branches, random memwait
        for (int t = 0; t < 12; t++) begin
            clear_mem();
            nprog = $urandom_range(6, 14);
            rxbyte = 8'($urandom);
            rxdata = rxbyte;
            for (int d = 100; d < 108; d++) put(d, 16'($urandom));
            for (int p = 0; p < nprog; p++) begin
                l = ops[$urandom_range(0, 11)];
                if (l == "L" || l == "R") opnd = $urandom_range(0, 40);
                else if (l == "E" || l == "G") opnd = $urandom_range(p + 1, nprog);
                else opnd = $urandom_range(100, 107);
                put(p, enc(l, opnd));
            end
            put(nprog, enc("Z", 0));
            model_run(macc, mpc, mex);
            do_reset();
            rnd_wait = 1'b1;
            run_until_halt("rand");
            chk("rand_acc", accout, macc);
            chk("rand_iaddr", iaddrout, 10'(mpc));
            chk("rand_illegal", illegal, 1'b0);
            chk("rand_exec_cycles", ex_cnt, mex);
            for (int d = 100; d < 108; d++) chk("rand_mem", mem[d], mm[d]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
